booth_product_accumulator: RTL and testbench



---
 rtl/booth_pkg.sv | 35 +++
 rtl/booth_sat_add.sv | 38 +++
 rtl/booth_product_accumulator.sv | 161 ++++++++++++++++
 tb/tb_booth_product_accumulator.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/booth_pkg.sv
// Shared types, constants and helpers for the Booth MAC back end.
// Holds the state encoding, accumulator bound helpers and the width check.
`ifndef BOOTH_PKG_MACROS
`define BOOTH_PKG_MACROS
`define BOOTH_WIDTH_CHECK(LBL, COND, MSG) \
    if (!(COND)) begin : LBL \
        $error(MSG); \
    end
`endif

package booth_pkg;

    typedef enum logic {
        ST_ACCUM = 1'b0,
        ST_HOLD  = 1'b1
    } state_e;

    // Widest accumulator the bound helpers can describe.
    localparam int unsigned BOUND_W = 256;

    // Largest positive value of a w-bit signed accumulator.
    function automatic logic [BOUND_W-1:0] acc_max(input int w);
        logic [BOUND_W-1:0] one;
        one = BOUND_W'(1);
        return (one << (w - 1)) - one;
    endfunction

    // Most negative value of a w-bit signed accumulator (pattern 100..0).
    function automatic logic [BOUND_W-1:0] acc_min(input int w);
        logic [BOUND_W-1:0] one;
        one = BOUND_W'(1);
        return one << (w - 1);
    endfunction

endpackage

// File: rtl/booth_sat_add.sv
// Combinational signed saturating adder: ACC_W accumulator plus P_W product.
// Result is clamped to the ACC_W signed range; ovf_out flags a clamp.
module booth_sat_add
    import booth_pkg::*;
#(
    parameter int ACC_W = 72,
    parameter int P_W   = 64
) (
    input  logic [ACC_W-1:0] acc_in,
    input  logic [P_W-1:0]   prod_in,
    output logic [ACC_W-1:0] sum_out,
    output logic             ovf_out
);

    `BOOTH_WIDTH_CHECK(g_chk_acc_w, ACC_W >= P_W, "booth_sat_add: ACC_W must be >= P_W")
    `BOOTH_WIDTH_CHECK(g_chk_bound, ACC_W <= BOUND_W, "booth_sat_add: ACC_W too wide")

    localparam logic [ACC_W-1:0] ACC_MAX = ACC_W'(acc_max(ACC_W));
    localparam logic [ACC_W-1:0] ACC_MIN = ACC_W'(acc_min(ACC_W));

    logic [ACC_W:0] ext_acc;
    logic [ACC_W:0] ext_prod;
    logic [ACC_W:0] raw;

    // One guard bit: the top two bits differ exactly when the sum left range.
    always_comb begin
        ext_acc  = {acc_in[ACC_W-1], acc_in};
        ext_prod = {{(ACC_W + 1 - P_W){prod_in[P_W-1]}}, prod_in};
        raw      = ext_acc + ext_prod;
        ovf_out  = raw[ACC_W] ^ raw[ACC_W-1];
        if (ovf_out) begin
            sum_out = raw[ACC_W] ? ACC_MIN : ACC_MAX;
        end else begin
            sum_out = raw[ACC_W-1:0];
        end
    end

endmodule

// File: rtl/booth_product_accumulator.sv
// Saturating group accumulator behind the sequential Booth multiplier.
// Sums products until the last beat, then holds the result for one handshake.
module booth_product_accumulator
    import booth_pkg::*;
#(
    parameter int N     = 32,
    parameter int ACC_W = 72,
    parameter int CNT_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [2*N-1:0]     in_prod,
    input  logic               in_last,
    input  logic               acc_clear,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [ACC_W-1:0]   out_sum,
    output logic [CNT_W-1:0]   out_count,
    output logic               out_sat
);

    `BOOTH_WIDTH_CHECK(g_chk_acc_w, ACC_W >= 2 * N, "booth_product_accumulator: ACC_W must be >= 2N")

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_e state_q;
    state_e state_d;

    logic [ACC_W-1:0] acc_q;
    logic [ACC_W-1:0] acc_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             sat_q;
    logic             sat_d;

    logic             out_valid_q;
    logic             out_valid_d;
    logic [ACC_W-1:0] out_sum_q;
    logic [ACC_W-1:0] out_sum_d;
    logic [CNT_W-1:0] out_count_q;
    logic [CNT_W-1:0] out_count_d;
    logic             out_sat_q;
    logic             out_sat_d;

    logic             accept;
    logic             clr_now;
    logic [ACC_W-1:0] acc_base;
    logic [CNT_W-1:0] cnt_base;
    logic             sat_base;
    logic [CNT_W-1:0] cnt_next;
    logic [ACC_W-1:0] add_sum;
    logic             add_ovf;

    booth_sat_add #(
        .ACC_W (ACC_W),
        .P_W   (2 * N)
    ) u_sat_add (
        .acc_in  (acc_base),
        .prod_in (in_prod),
        .sum_out (add_sum),
        .ovf_out (add_ovf)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_ACCUM;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: last beat enters HOLD, the result handshake returns to ACCUM.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_ACCUM: if (accept && in_last) state_d = ST_HOLD;
            ST_HOLD:  if (out_valid_q && out_ready) state_d = ST_ACCUM;
            default:  state_d = ST_ACCUM;
        endcase
    end

    // State outputs: ready depends on state only, never on out_ready.
    always_comb begin
        in_ready = (state_q == ST_ACCUM);
    end

    assign accept  = in_valid && in_ready;
    assign clr_now = acc_clear && (state_q == ST_ACCUM);

    // Clear takes effect before the same-cycle beat is summed.
    always_comb begin
        acc_base = clr_now ? '0 : acc_q;
        cnt_base = clr_now ? '0 : cnt_q;
        sat_base = clr_now ? 1'b0 : sat_q;
        cnt_next = (cnt_base == CNT_MAX) ? cnt_base : cnt_base + 1'b1;
    end

    // Running group state: add beats, zero on clear or when a group closes.
    always_comb begin
        acc_d = acc_base;
        cnt_d = cnt_base;
        sat_d = sat_base;
        if (accept) begin
            if (in_last) begin
                acc_d = '0;
                cnt_d = '0;
                sat_d = 1'b0;
            end else begin
                acc_d = add_sum;
                cnt_d = cnt_next;
                sat_d = sat_base | add_ovf;
            end
        end
    end

    // Result register: load on the last beat, drop valid on handshake.
    always_comb begin
        out_valid_d = out_valid_q;
        out_sum_d   = out_sum_q;
        out_count_d = out_count_q;
        out_sat_d   = out_sat_q;
        if (accept && in_last) begin
            out_valid_d = 1'b1;
            out_sum_d   = add_sum;
            out_count_d = cnt_next;
            out_sat_d   = sat_base | add_ovf;
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // Accumulator and result flops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q       <= '0;
            cnt_q       <= '0;
            sat_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_sum_q   <= '0;
            out_count_q <= '0;
            out_sat_q   <= 1'b0;
        end else begin
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            sat_q       <= sat_d;
            out_valid_q <= out_valid_d;
            out_sum_q   <= out_sum_d;
            out_count_q <= out_count_d;
            out_sat_q   <= out_sat_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_sum   = out_sum_q;
    assign out_count = out_count_q;
    assign out_sat   = out_sat_q;

endmodule

// File: tb/tb_booth_product_accumulator.sv
// Bench for booth_product_accumulator (N=8, ACC_W=18, CNT_W=4).
// Directed plan cases plus random traffic against a group-sum reference model.
module tb_booth_product_accumulator;

    localparam int N     = 8;
    localparam int ACC_W = 18;
    localparam int CNT_W = 4;
    localparam longint MAXV = 131071;
    localparam longint MINV = -131072;
    localparam int CMAX = 15;

    logic                    clk;
    logic                    rst;
    logic                    in_valid;
    logic                    in_ready;
    logic signed [2*N-1:0]   in_prod;
    logic                    in_last;
    logic                    acc_clear;
    logic                    out_valid;
    logic                    out_ready;
    logic signed [ACC_W-1:0] out_sum;
    logic [CNT_W-1:0]        out_count;
    logic                    out_sat;

    booth_product_accumulator #(
        .N     (N),
        .ACC_W (ACC_W),
        .CNT_W (CNT_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_prod   (in_prod),
        .in_last   (in_last),
        .acc_clear (acc_clear),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_count (out_count),
        .out_sat   (out_sat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: running group sum and the presented result.
    bit     m_hold;
    longint m_acc;
    int     m_cnt;
    bit     m_sat;
    bit     e_valid;
    longint e_sum;
    int     e_cnt;
    bit     e_sat;

    task automatic check(input string tag, input longint got, input longint exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_hold  = 0;
        m_acc   = 0;
        m_cnt   = 0;
        m_sat   = 0;
        e_valid = 0;
        e_sum   = 0;
        e_cnt   = 0;
        e_sat   = 0;
    endtask

    task automatic model_edge(input bit v, input longint p, input bit last,
                              input bit clr, input bit rdy);
        longint s;
        if (!m_hold) begin
            if (clr) begin
                m_acc = 0;
                m_cnt = 0;
                m_sat = 0;
            end
            if (v) begin
                s = m_acc + p;
                if (s > MAXV) begin
                    s = MAXV;
                    m_sat = 1;
                end else if (s < MINV) begin
                    s = MINV;
                    m_sat = 1;
                end
                m_acc = s;
                if (m_cnt < CMAX) m_cnt++;
                if (last) begin
                    e_sum   = m_acc;
                    e_cnt   = m_cnt;
                    e_sat   = m_sat;
                    e_valid = 1;
                    m_hold  = 1;
                    m_acc   = 0;
                    m_cnt   = 0;
                    m_sat   = 0;
                end
            end
        end else if (rdy) begin
            e_valid = 0;
            m_hold  = 0;
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".in_ready"}, longint'(in_ready), longint'(!m_hold));
        check({tag, ".out_valid"}, longint'(out_valid), longint'(e_valid));
        check({tag, ".out_sum"}, longint'(out_sum), e_sum);
        check({tag, ".out_count"}, longint'(out_count), longint'(e_cnt));
        check({tag, ".out_sat"}, longint'(out_sat), longint'(e_sat));
    endtask

    // One clock: drive inputs, advance the model on the edge, check at negedge.
    task automatic step(input string tag, input bit v, input longint p,
                        input bit last, input bit clr, input bit rdy);
        in_valid  = v;
        in_prod   = p[2*N-1:0];
        in_last   = last;
        acc_clear = clr;
        out_ready = rdy;
        @(posedge clk);
        model_edge(v, p, last, clr, rdy);
        @(negedge clk);
        check_all(tag);
    endtask

    task automatic idle(input string tag);
        step(tag, 0, 0, 0, 0, 1);
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_prod   = '0;
        in_last   = 1'b0;
        acc_clear = 1'b0;
        out_ready = 1'b0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        check("reset.out_valid", longint'(out_valid), 0);
        check("reset.out_sum", longint'(out_sum), 0);
        check("reset.out_count", longint'(out_count), 0);
        check("reset.out_sat", longint'(out_sat), 0);
        rst = 1'b0;
        @(negedge clk);
        check("reset.in_ready", longint'(in_ready), 1);

        // 1: simple three-term group
        step("t1", 1, 100, 0, 0, 1);
        step("t1", 1, -30, 0, 0, 1);
        step("t1", 1, 7, 1, 0, 1);
        check("t1.valid", longint'(out_valid), 1);
        check("t1.sum", longint'(out_sum), 77);
        check("t1.count", longint'(out_count), 3);
        check("t1.sat", longint'(out_sat), 0);
        check("t1.bubble", longint'(in_ready), 0);
        idle("t1");
        check("t1.ready_back", longint'(in_ready), 1);
        check("t1.valid_drop", longint'(out_valid), 0);

        // 2: positive then negative saturation
        for (int i = 0; i < 5; i++) step("t2p", 1, 32767, i == 4, 0, 1);
        check("t2.pos_sum", longint'(out_sum), 131071);
        check("t2.pos_sat", longint'(out_sat), 1);
        check("t2.pos_count", longint'(out_count), 5);
        idle("t2");
        for (int i = 0; i < 5; i++) step("t2n", 1, -32768, i == 4, 0, 1);
        check("t2.neg_sum", longint'(out_sum), -131072);
        check("t2.neg_sat", longint'(out_sat), 1);
        idle("t2");

        // 3: backpressure while the next beat waits
        step("t3", 1, 1, 0, 0, 1);
        step("t3", 1, 2, 1, 0, 0);
        for (int i = 0; i < 6; i++) begin
            step("t3hold", 1, 9, 0, 0, 0);
            check("t3.held_sum", longint'(out_sum), 3);
            check("t3.held_ready", longint'(in_ready), 0);
        end
        step("t3hs", 1, 9, 0, 0, 1);
        check("t3.after_hs_ready", longint'(in_ready), 1);
        step("t3", 1, 9, 0, 0, 1);
        step("t3", 1, 0, 1, 0, 1);
        check("t3.next_sum", longint'(out_sum), 9);
        check("t3.next_count", longint'(out_count), 2);
        idle("t3");

        // 4: clear together with a beat
        step("t4", 1, 1000, 0, 0, 1);
        step("t4", 1, 50, 0, 1, 1);
        step("t4", 1, 25, 1, 0, 1);
        check("t4.sum", longint'(out_sum), 75);
        check("t4.count", longint'(out_count), 2);
        check("t4.sat", longint'(out_sat), 0);
        idle("t4");

        // 5: term counter saturation
        for (int i = 0; i < 20; i++) step("t5", 1, 1, i == 19, 0, 1);
        check("t5.sum", longint'(out_sum), 20);
        check("t5.count", longint'(out_count), 15);
        check("t5.sat", longint'(out_sat), 0);
        idle("t5");

        // 6: asynchronous reset mid-group and mid-hold
        step("t6", 1, 500, 0, 0, 1);
        step("t6", 1, 600, 0, 0, 1);
        rst = 1'b1;
        #1;
        check("t6.rst_valid", longint'(out_valid), 0);
        #1;
        rst = 1'b0;
        model_reset();
        step("t6", 1, 4, 1, 0, 0);
        check("t6.sum", longint'(out_sum), 4);
        check("t6.count", longint'(out_count), 1);
        check("t6.valid", longint'(out_valid), 1);
        rst = 1'b1;
        #1;
        check("t6.hold_rst_valid", longint'(out_valid), 0);
        check("t6.hold_rst_sum", longint'(out_sum), 0);
        #1;
        rst = 1'b0;
        model_reset();
        idle("t6");

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            logic signed [15:0] r;
            longint p;
            r = 16'($urandom);
            if (($urandom % 4) != 0) begin
                p = longint'($urandom_range(600)) - 300;
            end else begin
                p = longint'(r);
            end
            step("rand", ($urandom % 4) != 0, p, ($urandom % 5) == 0,
                 ($urandom % 16) == 0, ($urandom % 3) != 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
